// File: rtl/wash_sensor_timer.sv
// -----------------------------------------------------------------------------
// wash_sensor_timer
//   Models the tub water level of a washing machine from the valve commands
//   and tracks the wash programme phase. It reports when the wash and spin
//   periods have elapsed, and raises a sticky fault on a stalled fill or on a
//   fill/drain conflict.
//
// Ports
//   Clock            in   rising-edge clock
//   Reset            in   asynchronous, active-low reset
//   Fill_valve_on    in   fill valve command
//   Drained_valve_on in   drain valve command
//   Motor_on         in   drum motor command
//   Door_Lock        in   door lock command (0 forces IDLE)
//   Supply_ok        in   mains water pressure present
//   Filled           out  Level == FULL_LEVEL
//   Drained          out  Level == 0
//   Cycle_Timeout    out  wash period elapsed
//   Spin_Timeout     out  spin period elapsed
//   Level[7:0]       out  modelled water level
//   Phase[1:0]       out  IDLE=0, FILL=1, WASH=2, SPIN=3
//   Fault            out  sticky fault flag
// -----------------------------------------------------------------------------
module wash_sensor_timer #(
  parameter int FULL_LEVEL  = 16,
  parameter int WASH_CYCLES = 20,
  parameter int SPIN_CYCLES = 12,
  parameter int FILL_LIMIT  = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Fill_valve_on,
  input  logic       Drained_valve_on,
  input  logic       Motor_on,
  input  logic       Door_Lock,
  input  logic       Supply_ok,
  output logic       Filled,
  output logic       Drained,
  output logic       Cycle_Timeout,
  output logic       Spin_Timeout,
  output logic [7:0] Level,
  output logic [1:0] Phase,
  output logic       Fault
);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_FILL = 2'd1;
  localparam logic [1:0] PH_WASH = 2'd2;
  localparam logic [1:0] PH_SPIN = 2'd3;

  localparam logic [7:0]  FULL_LVL = 8'(FULL_LEVEL);
  localparam logic [15:0] WASH_CNT = 16'(WASH_CYCLES);
  localparam logic [15:0] SPIN_CNT = 16'(SPIN_CYCLES);
  localparam logic [7:0]  FILL_LIM = 8'(FILL_LIMIT);

  logic [7:0]  level_r,    level_nxt_s;
  logic [1:0]  phase_r,    phase_nxt_s;
  logic [15:0] wash_cnt_r, wash_cnt_nxt_s;
  logic [15:0] spin_cnt_r, spin_cnt_nxt_s;
  logic [7:0]  fill_wd_r,  fill_wd_nxt_s;
  logic        cto_r,      cto_nxt_s;
  logic        sto_r,      sto_nxt_s;
  logic        fault_r,    fault_nxt_s;
  logic        conflict_s;

  // Water level model: fill and drain each move one step, saturating at the ends.
  always_comb begin
    level_nxt_s = level_r;
    if (Fill_valve_on && Supply_ok && !Drained_valve_on && (level_r < FULL_LVL)) begin
      level_nxt_s = level_r + 8'd1;
    end else if (Drained_valve_on && !Fill_valve_on && (level_r != 8'd0)) begin
      level_nxt_s = level_r - 8'd1;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Phase tracker; dropping the door lock always returns to IDLE.
  always_comb begin
    phase_nxt_s = phase_r;
    if (!Door_Lock) begin
      phase_nxt_s = PH_IDLE;
    end else begin
      case (phase_r)
        PH_IDLE: phase_nxt_s = Fill_valve_on ? PH_FILL : PH_IDLE;
        PH_FILL: phase_nxt_s = (Motor_on && !Fill_valve_on && !Drained_valve_on) ? PH_WASH : PH_FILL;
        PH_WASH: phase_nxt_s = Drained_valve_on ? PH_SPIN : PH_WASH;
        PH_SPIN: phase_nxt_s = (!Motor_on && !Drained_valve_on) ? PH_IDLE : PH_SPIN;
        default: phase_nxt_s = PH_IDLE;
      endcase
    end
  end

  // Wash timer: runs only while staying in WASH; entry, exit and door drop all clear it.
  always_comb begin
    wash_cnt_nxt_s = wash_cnt_r;
    cto_nxt_s      = cto_r;
    if ((phase_r == PH_WASH) && (phase_nxt_s == PH_WASH)) begin
      if (Motor_on && !cto_r) begin
        wash_cnt_nxt_s = wash_cnt_r + 16'd1;
        if (wash_cnt_nxt_s == WASH_CNT) begin
          cto_nxt_s = 1'b1;
        end else begin
          cto_nxt_s = cto_r;
        end
      end else begin
        wash_cnt_nxt_s = wash_cnt_r;
        cto_nxt_s      = cto_r;
      end
    end else begin
      wash_cnt_nxt_s = 16'd0;
      cto_nxt_s      = 1'b0;
    end
  end

  // Spin timer: counts only once the tub has fully drained.
  always_comb begin
    spin_cnt_nxt_s = spin_cnt_r;
    sto_nxt_s      = sto_r;
    if ((phase_r == PH_SPIN) && (phase_nxt_s == PH_SPIN)) begin
      if (Motor_on && (level_r == 8'd0) && !sto_r) begin
        spin_cnt_nxt_s = spin_cnt_r + 16'd1;
        if (spin_cnt_nxt_s == SPIN_CNT) begin
          sto_nxt_s = 1'b1;
        end else begin
          sto_nxt_s = sto_r;
        end
      end else begin
        spin_cnt_nxt_s = spin_cnt_r;
        sto_nxt_s      = sto_r;
      end
    end else begin
      spin_cnt_nxt_s = 16'd0;
      sto_nxt_s      = 1'b0;
    end
  end

  // Fill watchdog and sticky fault; the watchdog freezes once it has tripped.
  always_comb begin
    conflict_s    = Fill_valve_on && Drained_valve_on;
    fill_wd_nxt_s = fill_wd_r;
    fault_nxt_s   = fault_r | conflict_s;
    if (!Door_Lock) begin
      fill_wd_nxt_s = 8'd0;
    end else if ((phase_r != PH_FILL) && (phase_nxt_s == PH_FILL)) begin
      fill_wd_nxt_s = 8'd0;
    end else if ((phase_r == PH_FILL) && Fill_valve_on && (level_r < FULL_LVL) &&
                 (fill_wd_r != FILL_LIM)) begin
      fill_wd_nxt_s = fill_wd_r + 8'd1;
      if (fill_wd_nxt_s == FILL_LIM) begin
        fault_nxt_s = 1'b1;
      end else begin
        fault_nxt_s = fault_r | conflict_s;
      end
    end else begin
      fill_wd_nxt_s = fill_wd_r;
    end
  end

  // State registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      level_r    <= 8'd0;
      phase_r    <= PH_IDLE;
      wash_cnt_r <= 16'd0;
      spin_cnt_r <= 16'd0;
      fill_wd_r  <= 8'd0;
      cto_r      <= 1'b0;
      sto_r      <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      level_r    <= level_nxt_s;
      phase_r    <= phase_nxt_s;
      wash_cnt_r <= wash_cnt_nxt_s;
      spin_cnt_r <= spin_cnt_nxt_s;
      fill_wd_r  <= fill_wd_nxt_s;
      cto_r      <= cto_nxt_s;
      sto_r      <= sto_nxt_s;
      fault_r    <= fault_nxt_s;
    end
  end

  assign Level         = level_r;
  assign Phase         = phase_r;
  assign Filled        = (level_r == FULL_LVL);
  assign Drained       = (level_r == 8'd0);
  assign Cycle_Timeout = cto_r;
  assign Spin_Timeout  = sto_r;
  assign Fault         = fault_r;

endmodule
